alu64_mp_seq: RTL
=================

Name: alu64_mp_seq

Overview:
- Multi-precision operand sequencer sitting directly upstream of the 64-bit ripple-carry ALU (feeds its a/b/cin/op inputs) and capturing its s/cout outputs.
- Accepts one operation request covering 1..MAX_WORDS 64-bit words, streams operand words in LS-word-first order and drives each word into the ALU.
- Chains each word's cout into the next word's cin, waits a programmable settle time for the ripple chain, and returns result words on a valid/ready stream.

Parameters:
- MAX_WORDS, 4, maximum words per request (≥1).
- SETTLE_CYCLES, 2, clock cycles allowed for ALU ripple settling before capture (≥1).
- NW (derived), $clog2(MAX_WORDS)+1, width of word-count fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_op  in  2  ALU operation code, passed to ALU unmodified for every word
- req_cin  in  1  carry-in for word 0
- req_nwords  in  NW  words in this request
- opnd_valid  in  1  operand word valid
- opnd_ready  out  1  operand word ready
- opnd_a  in  64  operand A word
- opnd_b  in  64  operand B word
- res_valid  out  1  result word valid
- res_ready  in  1  result word ready
- res_s  out  64  result word
- res_cout  out  1  ALU carry-out of this word
- res_last  out  1  final word of request
- res_err  out  1  request rejected (bad word count)
- alu_a  out  64  to ALU a
- alu_b  out  64  to ALU b
- alu_cin  out  1  to ALU cin
- alu_op  out  2  to ALU op
- alu_s  in  64  from ALU s
- alu_cout  in  1  from ALU cout

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0, including req_ready (held 0 while rst_n low), alu_*, res_*; internal carry, word index and settle counter cleared.
- States: IDLE, WAIT_OPND, SETTLE, OUTPUT.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op, cin→carry reg, nwords; word_idx=0.
  - If req_nwords==0 or >MAX_WORDS: go OUTPUT with res_s=0, res_cout=0, res_err=1, res_last=1; no operand words are consumed.
  - Otherwise go WAIT_OPND.
- WAIT_OPND:
  - opnd_ready=1, all other readies 0.
  - On handshake, register alu_a=opnd_a, alu_b=opnd_b, alu_cin=carry reg, alu_op=latched op; load settle counter with SETTLE_CYCLES; go SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - At the edge where counter==1: capture res_s=alu_s, res_cout=alu_cout; carry reg=alu_cout; res_last=(word_idx==nwords-1); res_err=0; go OUTPUT.
  - Latency: res_valid asserts exactly SETTLE_CYCLES cycles after the operand handshake edge.
- OUTPUT:
  - res_valid=1; res_* held stable until res_ready.
  - On handshake: if res_last, go IDLE; else word_idx++ and go WAIT_OPND.
- alu_a/alu_b/alu_cin/alu_op change only on an operand handshake; they are stable through SETTLE and OUTPUT.
- Only one stream handshakes per cycle. Throughput is one word per SETTLE_CYCLES+2 cycles minimum. No overlap between requests.
- Carry chaining applies for every op code. The sequencer does not interpret op.
- Reset asserted mid-request aborts immediately. Partial results are discarded, and no res_valid follows deassertion.

Optional Feature:
- Macro ALU64_MP_SEQ_FLAGS_EN.
- Defined:
  - Adds outputs res_zero (1) and res_neg (1), valid with res_last.
  - res_zero=1 iff every result word of the request was all-zero; the accumulator is cleared on request accept.
  - res_neg=bit 63 of the final result word.
  - Both are 0 on error beats and after reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single word, op=OP_ADD (ALU add encoding), cin=0, a=64'h5, b=64'h7, SETTLE_CYCLES=2 -> res_s=64'hC, res_cout=0, res_last=1, res_valid 2 cycles after operand handshake.
- Two words, OP_ADD, a={64'h0,64'hFFFF_FFFF_FFFF_FFFF}, b={64'h0,64'h1} -> word0 res_s=0, res_cout=1; word1 alu_cin=1, res_s=64'h1, res_last=1.
- req_nwords=0, then req_nwords=MAX_WORDS+1 -> one beat each with res_err=1, res_last=1, res_s=0; opnd_ready never asserted.
- Backpressure: hold res_ready=0 for 5 cycles on word0 of 3 -> res_* and alu_* stable, opnd_ready=0; release -> words 1..2 processed correctly.
- Reset asserted during SETTLE of word1 of 3 -> all outputs 0 next sample; after release req_ready=1, no stray res_valid.
- FLAGS_EN: 2-word OP_ADD result {64'h8000_0000_0000_0000, 0} -> res_neg=1, res_zero=0; all-zero operands with cin=0 -> res_zero=1.

Source files
------------

// File: rtl/alu64_mp_seq.sv
// Multi-precision operand sequencer for a 64-bit ripple-carry ALU.
// Optional flags outputs (res_zero/res_neg) enabled by ALU64_MP_SEQ_FLAGS_EN.
module alu64_mp_seq #(
  parameter int MAX_WORDS     = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int NW            = $clog2(MAX_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic          req_cin,
  input  logic [NW-1:0] req_nwords,
  input  logic          opnd_valid,
  output logic          opnd_ready,
  input  logic [63:0]   opnd_a,
  input  logic [63:0]   opnd_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_s,
  output logic          res_cout,
  output logic          res_last,
  output logic          res_err,
`ifdef ALU64_MP_SEQ_FLAGS_EN
  output logic          res_zero,
  output logic          res_neg,
`endif
  output logic [63:0]   alu_a,
  output logic [63:0]   alu_b,
  output logic          alu_cin,
  output logic [1:0]    alu_op,
  input  logic [63:0]   alu_s,
  input  logic          alu_cout
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_OPND,
    S_SETTLE,
    S_OUTPUT
  } state_t;

  state_t          r_state;
  logic            r_req_ready;
  logic            r_opnd_ready;
  logic            r_res_valid;
  logic [63:0]     r_res_s;
  logic            r_res_cout;
  logic            r_res_last;
  logic            r_res_err;
  logic [63:0]     r_alu_a;
  logic [63:0]     r_alu_b;
  logic            r_alu_cin;
  logic [1:0]      r_alu_op;
  logic [1:0]      r_op;
  logic            r_carry;
  logic [NW-1:0]   r_nwords;
  logic [NW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
`ifdef ALU64_MP_SEQ_FLAGS_EN
  logic            r_zacc;
  logic            r_res_zero;
  logic            r_res_neg;
  logic            w_szero;
`endif

  logic w_bad;
  logic w_last;

  assign w_bad  = (req_nwords == '0) ||
                  (req_nwords > NW'(MAX_WORDS));
  assign w_last = (r_idx == r_nwords - NW'(1));
`ifdef ALU64_MP_SEQ_FLAGS_EN
  assign w_szero = (alu_s == 64'h0);
`endif

  // Request/operand/result sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_opnd_ready <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_s      <= '0;
      r_res_cout   <= 1'b0;
      r_res_last   <= 1'b0;
      r_res_err    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cin    <= 1'b0;
      r_alu_op     <= '0;
      r_op         <= '0;
      r_carry      <= 1'b0;
      r_nwords     <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
`ifdef ALU64_MP_SEQ_FLAGS_EN
      r_zacc       <= 1'b0;
      r_res_zero   <= 1'b0;
      r_res_neg    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_req_ready && req_valid) begin
            r_req_ready <= 1'b0;
            r_op        <= req_op;
            r_carry     <= req_cin;
            r_nwords    <= req_nwords;
            r_idx       <= '0;
`ifdef ALU64_MP_SEQ_FLAGS_EN
            r_zacc      <= 1'b1;
`endif
            if (w_bad) begin
              r_res_s     <= '0;
              r_res_cout  <= 1'b0;
              r_res_err   <= 1'b1;
              r_res_last  <= 1'b1;
              r_res_valid <= 1'b1;
`ifdef ALU64_MP_SEQ_FLAGS_EN
              r_res_zero  <= 1'b0;
              r_res_neg   <= 1'b0;
`endif
              r_state     <= S_OUTPUT;
            end else begin
              r_opnd_ready <= 1'b1;
              r_state      <= S_WAIT_OPND;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_WAIT_OPND: begin
          if (r_opnd_ready && opnd_valid) begin
            r_opnd_ready <= 1'b0;
            r_alu_a      <= opnd_a;
            r_alu_b      <= opnd_b;
            r_alu_cin    <= r_carry;
            r_alu_op     <= r_op;
            r_cnt        <= CW'(SETTLE_CYCLES);
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res_s     <= alu_s;
            r_res_cout  <= alu_cout;
            r_carry     <= alu_cout;
            r_res_last  <= w_last;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
`ifdef ALU64_MP_SEQ_FLAGS_EN
            r_zacc      <= r_zacc & w_szero;
            r_res_zero  <= w_last & r_zacc & w_szero;
            r_res_neg   <= w_last & alu_s[63];
`endif
            r_state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_res_last) begin
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_idx        <= r_idx + NW'(1);
              r_opnd_ready <= 1'b1;
              r_state      <= S_WAIT_OPND;
            end
          end
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign opnd_ready = r_opnd_ready;
  assign res_valid  = r_res_valid;
  assign res_s      = r_res_s;
  assign res_cout   = r_res_cout;
  assign res_last   = r_res_last;
  assign res_err    = r_res_err;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cin    = r_alu_cin;
  assign alu_op     = r_alu_op;
`ifdef ALU64_MP_SEQ_FLAGS_EN
  assign res_zero   = r_res_zero;
  assign res_neg    = r_res_neg;
`endif

endmodule
